// File: rtl/mmix_defs.sv
// Shared types for the MMIX memory port arbiter: access size, FSM state, requester id.
// Latency: none (types and a pure helper function only).
// Backpressure: none.
package mmix_defs;

  // MMIX access sizes; the value is log2 of the byte count.
  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WYDE  = 2'd1,
    TETRA = 2'd2,
    OCTA  = 2'd3
  } datasize_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_RD_DATA,
    S_WR_CMD,
    S_DONE
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  // Byte count minus one; also the low address bits that MMIX ignores.
  function automatic logic [2:0] size_m1(input datasize_e ds);
    case (ds)
      BYTE:    return 3'd0;
      WYDE:    return 3'd1;
      TETRA:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Maps a big-endian MMIX access onto the lanes of an octa-wide bus (byteenable, store shift, load extract).
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: datasize/addr_lo describe the access, wdata is right-justified store data, bus_rdata is the raw
//        bus word; byteenable (bit7 = lowest address), wdata_aligned and rdata_aligned (zero-extended).
module mem_lane_align
  import mmix_defs::*;
(
  input  logic [1:0]  datasize,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  input  logic [63:0] bus_rdata,
  output logic [7:0]  byteenable,
  output logic [63:0] wdata_aligned,
  output logic [63:0] rdata_aligned
);

  logic [2:0]  n_m1;
  logic [2:0]  off;
  logic [2:0]  lane;
  logic [5:0]  sh;
  logic [63:0] mask;
  logic [7:0]  be_base;

  always_comb begin
    n_m1    = size_m1(datasize_e'(datasize));
    // Misaligned low bits are dropped, so the access is always naturally aligned.
    off     = addr_lo & ~n_m1;
    // Lane index counted from the least significant byte: 8 - n - off.
    lane    = 3'd7 - off - n_m1;
    sh      = {lane, 3'b000};
    mask    = 64'hFFFF_FFFF_FFFF_FFFF;
    be_base = 8'hFF;
    case (datasize_e'(datasize))
      BYTE:    begin mask = 64'h0000_0000_0000_00FF; be_base = 8'h01; end
      WYDE:    begin mask = 64'h0000_0000_0000_FFFF; be_base = 8'h03; end
      TETRA:   begin mask = 64'h0000_0000_FFFF_FFFF; be_base = 8'h0F; end
      default: begin mask = 64'hFFFF_FFFF_FFFF_FFFF; be_base = 8'hFF; end
    endcase
    byteenable    = be_base << lane;
    wdata_aligned = (wdata & mask) << sh;
    rdata_aligned = (bus_rdata >> sh) & mask;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory bus between instruction fetch and the LSU, with MMIX lane alignment.
// Latency: command 1 cycle after request; write done = accept+1; read done = readdatavalid+1.
// Backpressure: bus command held until !avm_waitrequest; requesters hold their level until *_done.
// Ports: if_* fetch read port, ls_* load/store port, avm_* bus master; if_err/ls_err exist only when
//        MEM_ARB_TIMEOUT_EN is defined (watchdog drops a stuck bus cycle after TIMEOUT cycles).
module mem_port_arbiter
  import mmix_defs::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT  = 1023
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       if_address,
  input  logic [1:0]        if_datasize,
  input  logic              if_read,
  output logic [63:0]       if_readdata,
  output logic              if_done,
  input  logic [63:0]       ls_address,
  input  logic [1:0]        ls_datasize,
  input  logic              ls_read,
  input  logic              ls_write,
  input  logic [63:0]       ls_writedata,
  output logic [63:0]       ls_readdata,
  output logic              ls_done,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic              if_err,
  output logic              ls_err,
`endif
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [63:0]       avm_writedata,
  output logic [7:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [63:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_nxt;
  req_id_e           grant_q;
  logic [ADDR_W-4:0] cmd_addr_q;
  logic [1:0]        cmd_size_q;
  logic [2:0]        cmd_lo_q;
  logic [63:0]       cmd_wdata_q;
  logic [SW-1:0]     starve_q;
  logic [63:0]       if_rdata_q, ls_rdata_q;
  logic              ls_req, pick_if, load;
  logic              timeout_hit, timeout_fire;
  logic [63:0]       sel_addr;
  logic [1:0]        sel_size;
  logic [7:0]        be_raw;
  logic [63:0]       wdata_al, rdata_al;
  logic              unused_addr_bits;

  assign ls_req   = ls_read | ls_write;
  // Fetch wins only when the LSU is idle or fetch has been passed over STARVE_MAX times.
  assign pick_if  = if_read & (~ls_req | (starve_q == SW'(STARVE_MAX)));
  assign sel_addr = pick_if ? if_address : ls_address;
  assign sel_size = pick_if ? if_datasize : ls_datasize;
  assign load     = (state_q == S_IDLE) & (if_read | ls_req);
  assign unused_addr_bits = ^sel_addr[63:ADDR_W];

  // Alignment works from the latched command so a requester dropping its inputs mid-cycle is harmless.
  mem_lane_align u_align (
    .datasize      (cmd_size_q),
    .addr_lo       (cmd_lo_q),
    .wdata         (cmd_wdata_q),
    .bus_rdata     (avm_readdata),
    .byteenable    (be_raw),
    .wdata_aligned (wdata_al),
    .rdata_aligned (rdata_al)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt    = state_q;
    avm_read     = 1'b0;
    avm_write    = 1'b0;
    if_done      = 1'b0;
    ls_done      = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_if || ls_read) state_nxt = S_RD_CMD;
        else if (ls_write)      state_nxt = S_WR_CMD;
      end
      S_RD_CMD: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) state_nxt = S_RD_DATA;
        else if (timeout_hit) begin state_nxt = S_DONE; timeout_fire = 1'b1; end
      end
      S_RD_DATA: begin
        if (avm_readdatavalid) state_nxt = S_DONE;
        else if (timeout_hit)  begin state_nxt = S_DONE; timeout_fire = 1'b1; end
      end
      S_WR_CMD: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) state_nxt = S_DONE;
        else if (timeout_hit) begin state_nxt = S_DONE; timeout_fire = 1'b1; end
      end
      S_DONE: begin
        if_done   = (grant_q == REQ_IF);
        ls_done   = (grant_q == REQ_LS);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q     <= REQ_IF;
      cmd_addr_q  <= '0;
      cmd_size_q  <= '0;
      cmd_lo_q    <= '0;
      cmd_wdata_q <= '0;
    end else if (load) begin
      grant_q     <= pick_if ? REQ_IF : REQ_LS;
      cmd_addr_q  <= sel_addr[ADDR_W-1:3];
      cmd_size_q  <= sel_size;
      cmd_lo_q    <= sel_addr[2:0];
      cmd_wdata_q <= ls_writedata;
    end
  end

  // Counts LSU grants that pass over a waiting fetch; any gap in if_read restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              starve_q <= '0;
    else if (!if_read)                         starve_q <= '0;
    else if (load && pick_if)                  starve_q <= '0;
    else if (load && starve_q != SW'(STARVE_MAX)) starve_q <= starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else if (state_q == S_RD_DATA && avm_readdatavalid) begin
      if (grant_q == REQ_IF) if_rdata_q <= rdata_al;
      else                   ls_rdata_q <= rdata_al;
    end else if (timeout_fire) begin
      if (grant_q == REQ_IF) if_rdata_q <= '1;
      else                   ls_rdata_q <= '1;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt_q;
  logic          err_q;

  // Spans the whole bus transaction (command plus data wait), restarting for every grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     wd_cnt_q <= '0;
    else if (state_q == S_IDLE || state_q == S_DONE)  wd_cnt_q <= '0;
    else if (wd_cnt_q != TW'(TIMEOUT))                wd_cnt_q <= wd_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          err_q <= 1'b0;
    else if (load)         err_q <= 1'b0;
    else if (timeout_fire) err_q <= 1'b1;
  end

  assign timeout_hit = (wd_cnt_q == TW'(TIMEOUT));
  assign if_err      = if_done & err_q;
  assign ls_err      = ls_done & err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  assign avm_address    = {cmd_addr_q, 3'b000};
  assign avm_byteenable = (avm_read | avm_write) ? be_raw : 8'h00;
  assign avm_writedata  = avm_write ? wdata_al : 64'h0;
  assign if_readdata    = if_rdata_q;
  assign ls_readdata    = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus randomized single-port traffic against a byte-level model.
// Latency: checks command at request+1, write done at accept+1, read done at readdatavalid+1.
// Backpressure: drives avm_waitrequest stalls and delayed avm_readdatavalid.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [63:0]       if_address;
  logic [1:0]        if_datasize;
  logic              if_read;
  logic [63:0]       if_readdata;
  logic              if_done;
  logic [63:0]       ls_address;
  logic [1:0]        ls_datasize;
  logic              ls_read;
  logic              ls_write;
  logic [63:0]       ls_writedata;
  logic [63:0]       ls_readdata;
  logic              ls_done;
`ifdef MEM_ARB_TIMEOUT_EN
  logic              if_err;
  logic              ls_err;
`endif
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [63:0]       avm_writedata;
  logic [7:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [63:0]       avm_readdata;
  logic              avm_readdatavalid;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] m_if_rd, m_ls_rd;
  logic [31:0] cap_addr;
  logic [7:0]  cap_be;
  logic [63:0] cap_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
`ifdef MEM_ARB_TIMEOUT_EN
    , .TIMEOUT  (16)
`endif
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .if_address        (if_address),
    .if_datasize       (if_datasize),
    .if_read           (if_read),
    .if_readdata       (if_readdata),
    .if_done           (if_done),
    .ls_address        (ls_address),
    .ls_datasize       (ls_datasize),
    .ls_read           (ls_read),
    .ls_write          (ls_write),
    .ls_writedata      (ls_writedata),
    .ls_readdata       (ls_readdata),
    .ls_done           (ls_done),
`ifdef MEM_ARB_TIMEOUT_EN
    .if_err            (if_err),
    .ls_err            (ls_err),
`endif
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %h, required %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a big-endian octa where byte address k occupies bits [8*(7-k) +: 8].
  function automatic int m_base(input logic [63:0] a, input logic [1:0] sz);
    int n;
    n = 1 << sz;
    return (int'(a[2:0]) / n) * n;
  endfunction

  function automatic logic [7:0] m_be(input logic [63:0] a, input logic [1:0] sz);
    logic [7:0] be;
    int n, base;
    n = 1 << sz;
    base = m_base(a, sz);
    be = '0;
    for (int k = 0; k < n; k++) be[7-(base+k)] = 1'b1;
    return be;
  endfunction

  // Value byte j (j=0 least significant) lives at byte address base+n-1-j.
  function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] w;
    int n, base;
    n = 1 << sz;
    base = m_base(a, sz);
    w = '0;
    for (int j = 0; j < n; j++) w[8*(7-(base+n-1-j)) +: 8] = d[8*j +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_rdata(input logic [63:0] bus, input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] r;
    int n, base;
    n = 1 << sz;
    base = m_base(a, sz);
    r = '0;
    for (int j = 0; j < n; j++) r[8*j +: 8] = bus[8*(7-(base+n-1-j)) +: 8];
    return r;
  endfunction

  // One complete transaction from a single requester with a scripted bus response.
  task automatic do_txn(input bit is_if, input bit is_wr, input logic [63:0] addr, input logic [1:0] sz,
                        input logic [63:0] wd, input logic [63:0] busd, input int stall, input int rdly);
    logic [31:0] exp_addr;
    bit          stable;
    bit          early;
    exp_addr = {addr[31:3], 3'b000};
    if (is_if) begin
      if_address = addr; if_datasize = sz; if_read = 1'b1;
    end else begin
      ls_address = addr; ls_datasize = sz; ls_writedata = wd;
      ls_read = !is_wr; ls_write = is_wr;
    end
    avm_waitrequest = 1'b1;
    tick();
    cap_addr = avm_address; cap_be = avm_byteenable; cap_wdata = avm_writedata;
    chk("cmd_issue", is_wr ? avm_write : avm_read, 1'b1);
    chk("cmd_addr", avm_address, exp_addr);
    chk("cmd_be", avm_byteenable, m_be(addr, sz));
    if (is_wr) chk("cmd_wdata", avm_writedata, m_wdata(wd, addr, sz));
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      tick();
      if ((is_wr ? avm_write : avm_read) !== 1'b1 || avm_address !== exp_addr ||
          avm_byteenable !== m_be(addr, sz) || if_done || ls_done) stable = 1'b0;
    end
    if (stall > 0) chk("stall_hold", stable, 1'b1);
    avm_waitrequest = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    if (!is_wr) begin
      chk("cmd_drop", avm_read | avm_write, 1'b0);
      early = 1'b0;
      for (int d = 0; d < rdly; d++) begin
        tick();
        if (if_done || ls_done) early = 1'b1;
      end
      chk("no_early_done", early, 1'b0);
      avm_readdata = busd;
      avm_readdatavalid = 1'b1;
      tick();
      avm_readdatavalid = 1'b0;
      if (is_if) m_if_rd = m_rdata(busd, addr, sz);
      else       m_ls_rd = m_rdata(busd, addr, sz);
    end
    chk("done_pulse", {if_done, ls_done}, is_if ? 2'b10 : 2'b01);
    if_read = 1'b0; ls_read = 1'b0; ls_write = 1'b0;
    chk("if_readdata", if_readdata, m_if_rd);
    chk("ls_readdata", ls_readdata, m_ls_rd);
    tick();
    chk("done_once", {if_done, ls_done}, 2'b00);
  endtask

  initial begin
    int  ls_before, both, got_k;
    bit  if_seen, acc, quiet;
    logic [63:0] last_beat;

    reset_n = 1'b0;
    if_address = '0; if_datasize = '0; if_read = 1'b0;
    ls_address = '0; ls_datasize = '0; ls_read = 1'b0; ls_write = 1'b0; ls_writedata = '0;
    avm_waitrequest = 1'b1; avm_readdata = '0; avm_readdatavalid = 1'b0;
    m_if_rd = '0; m_ls_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avm_read", avm_read, 1'b0);
    chk("rst_avm_write", avm_write, 1'b0);
    chk("rst_avm_address", avm_address, 32'h0);
    chk("rst_avm_be", avm_byteenable, 8'h00);
    chk("rst_avm_wdata", avm_writedata, 64'h0);
    chk("rst_dones", {if_done, ls_done}, 2'b00);
    chk("rst_if_readdata", if_readdata, 64'h0);
    chk("rst_ls_readdata", ls_readdata, 64'h0);
    reset_n = 1'b1;
    tick();

    // STB to 0x1003.
    do_txn(1'b0, 1'b1, 64'h1003, 2'd0, 64'hAB, 64'h0, 2, 0);
    chk("stb_addr", cap_addr, 32'h1000);
    chk("stb_be", cap_be, 8'b0001_0000);
    chk("stb_lane", cap_wdata[39:32], 8'hAB);
    chk("stb_wdata", cap_wdata, 64'h0000_00AB_0000_0000);

    // LDT from 0x2006.
    do_txn(1'b0, 1'b0, 64'h2006, 2'd2, 64'h0, 64'h0011_2233_4455_6677, 0, 1);
    chk("ldt_rdata", ls_readdata, 64'h0000_0000_4455_6677);

    // Long waitrequest on a fetch read.
    do_txn(1'b1, 1'b0, 64'h0000_0000_0000_3F08, 2'd3, 64'h0, 64'hDEAD_BEEF_0123_4567, 5, 2);
    chk("fetch_octa", if_readdata, 64'hDEAD_BEEF_0123_4567);

    // Fetch and LSU both held: LSU gets STARVE_MAX grants, then fetch.
    if_address = 64'h3000; if_datasize = 2'd3; if_read = 1'b1;
    ls_address = 64'h4000; ls_datasize = 2'd3; ls_read = 1'b1;
    avm_waitrequest = 1'b0;
    ls_before = 0; both = 0; if_seen = 1'b0; acc = 1'b0; last_beat = '0;
    for (int c = 0; c < 80 && !if_seen; c++) begin
      tick();
      if (if_done && ls_done) both++;
      if (ls_done) begin
        ls_before++;
        m_ls_rd = m_rdata(last_beat, ls_address, ls_datasize);
        chk("cont_ls_rd", ls_readdata, m_ls_rd);
      end
      if (if_done) begin
        if_seen = 1'b1;
        if_read = 1'b0; ls_read = 1'b0;
        m_if_rd = m_rdata(last_beat, if_address, if_datasize);
        chk("cont_if_rd", if_readdata, m_if_rd);
      end
      avm_readdatavalid = acc;
      if (acc) begin
        last_beat = {$urandom, $urandom};
        avm_readdata = last_beat;
      end
      acc = avm_read;
    end
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b1;
    chk("fetch_granted", if_seen, 1'b1);
    chk("lsu_grants_before_fetch", ls_before, STARVE_MAX);
    chk("double_done", both, 0);
    tick(); tick();
    chk("cont_idle", avm_read | avm_write, 1'b0);

    // Randomized single-requester traffic.
    for (int t = 0; t < 60; t++) begin
      bit          r_if, r_wr;
      logic [1:0]  r_sz;
      r_if = ($urandom_range(0, 2) == 0);
      r_wr = !r_if && ($urandom_range(0, 1) == 1);
      r_sz = 2'($urandom_range(0, 3));
      do_txn(r_if, r_wr, {$urandom, $urandom}, r_sz, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Reset while waiting for read data; the late beat must be ignored.
    ls_address = 64'h5008; ls_datasize = 2'd3; ls_read = 1'b1; avm_waitrequest = 1'b0;
    tick();
    tick();
    avm_waitrequest = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_avm_read", avm_read, 1'b0);
    chk("mid_rst_avm_address", avm_address, 32'h0);
    chk("mid_rst_be", avm_byteenable, 8'h00);
    chk("mid_rst_dones", {if_done, ls_done}, 2'b00);
    chk("mid_rst_ls_rd", ls_readdata, 64'h0);
    chk("mid_rst_if_rd", if_readdata, 64'h0);
    m_if_rd = '0; m_ls_rd = '0;
    ls_read = 1'b0;
    tick();
    reset_n = 1'b1;
    avm_readdata = 64'h1234_5678_9ABC_DEF0;
    avm_readdatavalid = 1'b1;
    tick();
    avm_readdatavalid = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (if_done || ls_done) quiet = 1'b0;
      tick();
    end
    chk("late_rdv_no_done", quiet, 1'b1);
    chk("late_rdv_ls_rd", ls_readdata, m_ls_rd);

`ifdef MEM_ARB_TIMEOUT_EN
    // Read accepted but data never returns.
    ls_address = 64'h6000; ls_datasize = 2'd3; ls_read = 1'b1; avm_waitrequest = 1'b0;
    tick();
    got_k = -1;
    for (int k = 1; k <= 40 && got_k < 0; k++) begin
      tick();
      avm_waitrequest = 1'b1;
      if (ls_done) begin
        got_k = k;
        chk("to_err", ls_err, 1'b1);
        chk("to_data", ls_readdata, 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
    chk("to_cycle", got_k, 17);
    ls_read = 1'b0;
    tick();
`else
    got_k = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
